// File: rtl/memory_unit_if.sv
// Processor/loader bus between memory_unit and its requesters.
// master drives address/write/loader inputs; slave is the memory.
interface memory_unit_if #(
    parameter int DATAWIDTH = 8,
    parameter int ADDRWIDTH = 8
);
    logic [ADDRWIDTH-1:0] address;
    logic [DATAWIDTH-1:0] data_in;
    logic                 write;
    logic [DATAWIDTH-1:0] data_out;
    logic                 load_valid;
    logic [DATAWIDTH-1:0] load_data;
    logic                 load_last;
    logic                 load_ready;
    logic                 reload;
    logic                 cpu_run;
    logic [ADDRWIDTH:0]   words_loaded;

    modport master (
        output address, data_in, write,
        output load_valid, load_data, load_last, reload,
        input  data_out, load_ready, cpu_run, words_loaded
    );

    modport slave (
        input  address, data_in, write,
        input  load_valid, load_data, load_last, reload,
        output data_out, load_ready, cpu_run, words_loaded
    );
endinterface

// File: rtl/memory_unit.sv
// Unified RISC-SPM program/data memory with a byte-stream loader
// that holds the processor in reset until the image is in place.
module memory_unit #(
    parameter int DATAWIDTH = 8,
    parameter int ADDRWIDTH = 8
) (
    input  logic           clk,
    input  logic           clr,
    memory_unit_if.slave   bus
);
    localparam int DEPTH = 2 ** ADDRWIDTH;

    typedef enum logic [1:0] {
        ST_LOAD = 2'b01,
        ST_RUN  = 2'b10
    } state_e;

    state_e               state_q, state_d;
    logic [ADDRWIDTH-1:0] ptr_q, ptr_d;
    logic [ADDRWIDTH:0]   words_q, words_d;

    logic [DATAWIDTH-1:0] mem_q [DEPTH];
    logic                 mem_we;
    logic [ADDRWIDTH-1:0] mem_waddr;
    logic [DATAWIDTH-1:0] mem_wdata;

    logic running;
    logic ptr_full;

    // Anything other than RUN, including illegal encodings, is LOAD.
    assign running  = (state_q == ST_RUN);
    assign ptr_full = (ptr_q == {ADDRWIDTH{1'b1}});

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        words_d   = words_q;
        mem_we    = 1'b0;
        mem_waddr = bus.address;
        mem_wdata = bus.data_in;
        case (state_q)
            ST_RUN: begin
                mem_we = bus.write;
                if (bus.reload) begin
                    state_d = ST_LOAD;
                    ptr_d   = '0;
                    words_d = '0;
                end
            end
            default: begin
                state_d = ST_LOAD;
                if (bus.load_valid) begin
                    mem_we    = 1'b1;
                    mem_waddr = ptr_q;
                    mem_wdata = bus.load_data;
                    ptr_d     = ptr_q + 1'b1;
                    words_d   = words_q + 1'b1;
                    // A full image forces RUN before ptr can revisit word 0.
                    if (bus.load_last || ptr_full) begin
                        state_d = ST_RUN;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= ST_LOAD;
            ptr_q   <= '0;
            words_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            words_q <= words_d;
        end
    end

    // Contents are deliberately not reset so images survive clr/reload.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign bus.data_out     = running ? mem_q[bus.address] : '0;
    assign bus.load_ready   = ~running;
    assign bus.cpu_run      = running;
    assign bus.words_loaded = words_q;
endmodule

// File: tb/tb_memory_unit.sv
// Directed bench for memory_unit against an array/flag model.
// Inputs change 1 time unit after the falling edge; checks on the falling edge.
module tb_memory_unit;
    logic clk = 1'b0;
    logic clr = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    memory_unit_if #(.DATAWIDTH(8), .ADDRWIDTH(8)) bus ();

    memory_unit #(.DATAWIDTH(8), .ADDRWIDTH(8)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus.slave)
    );

    logic [7:0] m_mem   [256];
    bit         m_known [256];
    bit         m_run;
    int         m_ptr;
    int         m_words;

    function automatic void chk(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Model: the image is an array filled in stream order; RUN after
    // the last-flagged byte or the 256th byte of a load.
    always @(posedge clk or negedge clr) begin
        if (!clr) begin
            m_run   <= 1'b0;
            m_ptr   <= 0;
            m_words <= 0;
        end else if (!m_run) begin
            if (bus.load_valid) begin
                m_mem[m_ptr]   <= bus.load_data;
                m_known[m_ptr] <= 1'b1;
                m_ptr          <= (m_ptr + 1) % 256;
                m_words        <= m_words + 1;
                if (bus.load_last || m_words + 1 == 256) m_run <= 1'b1;
            end
        end else begin
            if (bus.write) begin
                m_mem[bus.address]   <= bus.data_in;
                m_known[bus.address] <= 1'b1;
            end
            if (bus.reload) begin
                m_run   <= 1'b0;
                m_ptr   <= 0;
                m_words <= 0;
            end
        end
    end

    always @(negedge clk) begin
        chk("load_ready", int'(bus.load_ready), int'(!m_run));
        chk("cpu_run", int'(bus.cpu_run), int'(m_run));
        chk("words_loaded", int'(bus.words_loaded), m_words);
        if (!m_run)
            chk("data_out_load", int'(bus.data_out), 0);
        else if (m_known[bus.address])
            chk("data_out_run", int'(bus.data_out), int'(m_mem[bus.address]));
    end

    task automatic cyc(int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic rd(string name, logic [7:0] a, logic [7:0] exp);
        bus.address = a;
        #1;
        chk(name, int'(bus.data_out), int'(exp));
    endtask

    task automatic do_reload();
        bus.reload = 1'b1;
        cyc();
        bus.reload = 1'b0;
    endtask

    initial begin
        bus.address    = '0;
        bus.data_in    = '0;
        bus.write      = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_data  = '0;
        bus.load_last  = 1'b0;
        bus.reload     = 1'b0;
        cyc(2);
        chk("rst_ready", int'(bus.load_ready), 1);
        chk("rst_run", int'(bus.cpu_run), 0);
        chk("rst_words", int'(bus.words_loaded), 0);
        chk("rst_dout", int'(bus.data_out), 0);
        clr = 1'b1;
        cyc();

        // 4-byte load with last on the 4th
        bus.load_valid = 1'b1;
        bus.load_data = 8'h51; cyc();
        bus.load_data = 8'h60; cyc();
        bus.load_data = 8'h0A; cyc();
        chk("run_before_last", int'(bus.cpu_run), 0);
        bus.load_data = 8'h00; bus.load_last = 1'b1; cyc();
        bus.load_valid = 1'b0; bus.load_last = 1'b0;
        chk("run_after_last", int'(bus.cpu_run), 1);
        chk("ready_after_last", int'(bus.load_ready), 0);
        chk("words4", int'(bus.words_loaded), 4);
        rd("rd_addr2", 8'h02, 8'h0A);
        rd("rd_addr0", 8'h00, 8'h51);
        cyc();

        // RUN write then same-address read next cycle
        bus.address = 8'h80; bus.data_in = 8'hA5; bus.write = 1'b1;
        cyc();
        bus.write = 1'b0;
        rd("wr_80", 8'h80, 8'hA5);
        cyc();

        // reload together with a write; write must commit
        bus.address = 8'h10; bus.data_in = 8'h3C; bus.write = 1'b1;
        do_reload();
        bus.write = 1'b0;
        chk("reload_run", int'(bus.cpu_run), 0);
        chk("reload_words", int'(bus.words_loaded), 0);
        bus.load_valid = 1'b1; bus.load_data = 8'h77; bus.load_last = 1'b1;
        cyc();
        bus.load_valid = 1'b0; bus.load_last = 1'b0;
        chk("one_byte_run", int'(bus.cpu_run), 1);
        chk("one_byte_words", int'(bus.words_loaded), 1);
        rd("one_byte_a0", 8'h00, 8'h77);
        rd("reload_wr_10", 8'h10, 8'h3C);
        cyc();

        // LOAD ignores processor writes; then a gapped load
        do_reload();
        bus.address = 8'h80; bus.data_in = 8'h11; bus.write = 1'b1;
        cyc();
        bus.write = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.load_valid = (i % 2 == 0);
            bus.load_data  = 8'hB0 + 8'(i);
            bus.load_last  = (i == 4);
            cyc();
        end
        bus.load_valid = 1'b0; bus.load_last = 1'b0;
        chk("gap_words", int'(bus.words_loaded), 3);
        rd("gap_a0", 8'h00, 8'hB0);
        rd("gap_a1", 8'h01, 8'hB2);
        rd("gap_a2", 8'h02, 8'hB4);
        rd("load_wr_ignored", 8'h80, 8'hA5);
        cyc();

        // 256-byte stream with no last: auto-RUN when full
        do_reload();
        bus.load_valid = 1'b1;
        for (int i = 0; i < 256; i++) begin
            bus.load_data = 8'(i) ^ 8'h5A;
            cyc();
        end
        bus.load_data = 8'hFF;
        chk("full_run", int'(bus.cpu_run), 1);
        chk("full_ready", int'(bus.load_ready), 0);
        chk("full_words", int'(bus.words_loaded), 256);
        cyc();
        bus.load_valid = 1'b0;
        chk("byte257_words", int'(bus.words_loaded), 256);
        rd("full_a0", 8'h00, 8'h5A);
        rd("full_aff", 8'hFF, 8'hA5);
        cyc();

        // clr mid-load aborts; restart begins at addr 0
        do_reload();
        bus.load_valid = 1'b1;
        bus.load_data = 8'hC1; cyc();
        bus.load_data = 8'hC2; cyc();
        bus.load_valid = 1'b0;
        #1 clr = 1'b0;
        #1;
        chk("clr_run", int'(bus.cpu_run), 0);
        chk("clr_words", int'(bus.words_loaded), 0);
        chk("clr_ready", int'(bus.load_ready), 1);
        cyc();
        clr = 1'b1;
        bus.load_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.load_data = 8'hD0 + 8'(i);
            bus.load_last = (i == 4);
            cyc();
        end
        bus.load_valid = 1'b0; bus.load_last = 1'b0;
        chk("restart_words", int'(bus.words_loaded), 5);
        rd("restart_a0", 8'h00, 8'hD0);
        rd("restart_a4", 8'h04, 8'hD4);
        rd("restart_a5_kept", 8'h05, 8'h5F);

        // clr in RUN drops cpu_run asynchronously
        #1 clr = 1'b0;
        #1;
        chk("clr_in_run", int'(bus.cpu_run), 0);
        chk("clr_in_run_dout", int'(bus.data_out), 0);
        cyc();
        clr = 1'b1;
        cyc(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
